// File: rtl/bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler
//
// Resolves the branch sitting in ID against what IF predicted, drives the PC
// redirect on a misprediction, and queues the resulting BHT/BTB update in a
// small FIFO. The predictor tables have a single port, so this block also
// arbitrates that port between fetch lookups and queued updates. A lookup that
// hits the same index as the head update wins the port until the update has
// been blocked for STARVE_LIM consecutive cycles. At that point the update
// takes the port and the lookup is stalled.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   enable                pipeline advance (0 = ID stalled, nothing enqueued)
//   lookup_valid, PC_curr fetch lookup request and PC
//   IF_ID_*               PC, 2-bit counter and target predicted for the ID insn
//   was_branch            ID instruction is a branch
//   actual_taken/target   resolved outcome
//   branch_mispredicted   combinational mispredict flag
//   redirect_pc           correct next PC
//   tbl_wen, tbl_widx     table write strobe and index
//   bht_wdata             new 2-bit counter value
//   btb_wen, btb_wdata    BTB write qualifier and target
//   lookup_stall          fetch lookup denied this cycle
//   upd_full              update FIFO holds DEPTH entries
//
// Optional feature (macro BP_FWD_EN)
//   Adds fwd_hit / fwd_counter / fwd_target. These forward the youngest queued
//   update whose index matches the fetch PC, so IF can override stale table
//   data before the update drains.
// -----------------------------------------------------------------------------
module bp_update_scheduler #(
    parameter int PC_W       = 16,
    parameter int IDX_W      = 3,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  PC_curr,
    input  logic [PC_W-1:0]  IF_ID_PC_curr,
    input  logic [1:0]       IF_ID_prediction,
    input  logic [PC_W-1:0]  IF_ID_pred_target,
    input  logic             was_branch,
    input  logic             actual_taken,
    input  logic [PC_W-1:0]  actual_target,
    output logic             branch_mispredicted,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             tbl_wen,
    output logic [IDX_W-1:0] tbl_widx,
    output logic [1:0]       bht_wdata,
    output logic             btb_wen,
    output logic [PC_W-1:0]  btb_wdata,
    output logic             lookup_stall,
    output logic             upd_full
`ifdef BP_FWD_EN
    ,
    output logic             fwd_hit,
    output logic [1:0]       fwd_counter,
    output logic [PC_W-1:0]  fwd_target
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
        logic [PC_W-1:0]  target;
        logic             taken;
    } upd_t;

    // NOTE: the entry storage has no reset; an entry is only observable once
    // the occupancy count covers it, so clearing the pointers is enough.
    upd_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [STV_W-1:0]  starve_q, starve_d;

    // ---------------------------------------------------------------- resolve
    logic             mispred;
    logic [1:0]       new_ctr;
    upd_t             new_entry;
    logic [IDX_W-1:0] lookup_idx;
    logic             unused_pc_bits;

    assign mispred = was_branch
                   & ((IF_ID_prediction[1] != actual_taken)
                   | (actual_taken & (IF_ID_pred_target != actual_target)));

    // NOTE: every always_comb output gets a default on entry so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        new_ctr = IF_ID_prediction;
        if (actual_taken) begin
            if (IF_ID_prediction != 2'b11) new_ctr = IF_ID_prediction + 2'd1;
        end else begin
            if (IF_ID_prediction != 2'b00) new_ctr = IF_ID_prediction - 2'd1;
        end
    end

    assign new_entry  = '{idx:    IF_ID_PC_curr[IDX_W:1],
                          ctr:    new_ctr,
                          target: actual_target,
                          taken:  actual_taken};
    assign lookup_idx = PC_curr[IDX_W:1];

    // Halfword alignment bit and the high PC bits never index the tables.
    assign unused_pc_bits = ^{PC_curr[PC_W-1:IDX_W+1], PC_curr[0]};

    assign branch_mispredicted = !rst & mispred;
    assign redirect_pc = rst          ? '0 :
                         actual_taken ? actual_target :
                                        IF_ID_PC_curr + PC_W'(2);

    // -------------------------------------------------------------- arbitrate
    upd_t head;
    logic empty, full, conflict, at_limit, grant, push, pop;

    assign head     = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign conflict = lookup_valid & (lookup_idx == head.idx);
    assign at_limit = (starve_q == STV_W'(STARVE_LIM));
    assign grant    = !rst & !empty & (!conflict | at_limit);
    assign pop      = grant;
    // A full FIFO still accepts an update when the head drains in the same cycle.
    assign push     = !rst & enable & was_branch & (!full | pop);

    assign tbl_wen      = grant;
    assign lookup_stall = grant & conflict;
    assign tbl_widx     = grant ? head.idx    : '0;
    assign bht_wdata    = grant ? head.ctr    : '0;
    assign btb_wen      = grant & head.taken;
    assign btb_wdata    = grant ? head.target : '0;
    assign upd_full     = !rst & full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The starvation count only advances while an update is waiting and
        // loses the port. It never exceeds STARVE_LIM because the limit grants.
        if (empty || grant) starve_d = '0;
        else                starve_d = starve_q + STV_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

`ifdef BP_FWD_EN
    // Scan oldest to youngest so the last match, which is the youngest, wins.
    always_comb begin
        fwd_hit     = 1'b0;
        fwd_counter = '0;
        fwd_target  = '0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count_q) &&
                    (mem_q[rd_ptr_q + PTR_W'(i)].idx == lookup_idx)) begin
                    fwd_hit     = 1'b1;
                    fwd_counter = mem_q[rd_ptr_q + PTR_W'(i)].ctr;
                    fwd_target  = mem_q[rd_ptr_q + PTR_W'(i)].target;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bp_update_scheduler
//
// Self-checking bench for bp_update_scheduler. Each accepted branch pushes its
// expected table write to a scoreboard queue. A monitor pops the queue and
// compares at every table write strobe. Resolution outputs, arbitration
// timing, FIFO full/drop behaviour and reset are checked directly.
// -----------------------------------------------------------------------------
module tb_bp_update_scheduler;

    localparam int PC_W  = 16;
    localparam int IDX_W = 3;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
        logic [PC_W-1:0]  target;
        logic             taken;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b1;
    logic             lookup_valid = 1'b0;
    logic [PC_W-1:0]  PC_curr = '0;
    logic [PC_W-1:0]  IF_ID_PC_curr = '0;
    logic [1:0]       IF_ID_prediction = '0;
    logic [PC_W-1:0]  IF_ID_pred_target = '0;
    logic             was_branch = 1'b0;
    logic             actual_taken = 1'b0;
    logic [PC_W-1:0]  actual_target = '0;
    logic             branch_mispredicted;
    logic [PC_W-1:0]  redirect_pc;
    logic             tbl_wen;
    logic [IDX_W-1:0] tbl_widx;
    logic [1:0]       bht_wdata;
    logic             btb_wen;
    logic [PC_W-1:0]  btb_wdata;
    logic             lookup_stall;
    logic             upd_full;
`ifdef BP_FWD_EN
    logic             fwd_hit;
    logic [1:0]       fwd_counter;
    logic [PC_W-1:0]  fwd_target;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    bp_update_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .lookup_valid        (lookup_valid),
        .PC_curr             (PC_curr),
        .IF_ID_PC_curr       (IF_ID_PC_curr),
        .IF_ID_prediction    (IF_ID_prediction),
        .IF_ID_pred_target   (IF_ID_pred_target),
        .was_branch          (was_branch),
        .actual_taken        (actual_taken),
        .actual_target       (actual_target),
        .branch_mispredicted (branch_mispredicted),
        .redirect_pc         (redirect_pc),
        .tbl_wen             (tbl_wen),
        .tbl_widx            (tbl_widx),
        .bht_wdata           (bht_wdata),
        .btb_wen             (btb_wen),
        .btb_wdata           (btb_wdata),
        .lookup_stall        (lookup_stall),
        .upd_full            (upd_full)
`ifdef BP_FWD_EN
        ,
        .fwd_hit             (fwd_hit),
        .fwd_counter         (fwd_counter),
        .fwd_target          (fwd_target)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] sat_ctr(input logic [1:0] p, input logic t);
        if (t) return (p == 2'b11) ? 2'b11 : p + 2'd1;
        else   return (p == 2'b00) ? 2'b00 : p - 2'd1;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one ID-stage instruction, check resolution 2ns later, and record
    // the expected table write when the update should be accepted.
    task automatic drive_br(input string tag, input logic wb, input logic [PC_W-1:0] pc,
                            input logic [1:0] pred, input logic [PC_W-1:0] ptgt,
                            input logic taken, input logic [PC_W-1:0] tgt,
                            input logic accept, input logic exp_mis,
                            input logic [PC_W-1:0] exp_redir);
        exp_t e;
        was_branch        = wb;
        IF_ID_PC_curr     = pc;
        IF_ID_prediction  = pred;
        IF_ID_pred_target = ptgt;
        actual_taken      = taken;
        actual_target     = tgt;
        #2;
        check({tag, "_mispred"}, branch_mispredicted, exp_mis);
        check({tag, "_redirect"}, redirect_pc, exp_redir);
        if (accept) begin
            e.idx    = pc[IDX_W:1];
            e.ctr    = sat_ctr(pred, taken);
            e.target = tgt;
            e.taken  = taken;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        was_branch = 1'b0;
    endtask

    // Scoreboard monitor: every table write must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tbl_wen === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_write", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_idx", tbl_widx, e.idx);
                    check("wr_bht", bht_wdata, e.ctr);
                    check("wr_btb_wen", btb_wen, e.taken);
                    if (e.taken) check("wr_btb_data", btb_wdata, e.target);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset forces every output low even with a mispredicting branch.
        tick();
        drive_br("rst", 1'b1, 16'h0008, 2'b01, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000);
        check("rst_tbl_wen", tbl_wen, 0);
        check("rst_upd_full", upd_full, 0);
        check("rst_stall", lookup_stall, 0);
        check("rst_btb_wen", btb_wen, 0);
        tick();
        rst = 1'b0;
        idle();
        #2;
        check("post_rst_tbl_wen", tbl_wen, 0);
        check("post_rst_upd_full", upd_full, 0);
        tick();

        // 2: taken mispredict, written on the next cycle.
        drive_br("t2", 1'b1, 16'h0008, 2'b01, 16'h0000, 1'b1, 16'h0080, 1'b1, 1'b1, 16'h0080);
        tick(); idle(); #2;
        check("t2_latency_wen", tbl_wen, 1);
        tick(); tick();

        // 3: not-taken with saturation, target mismatch, PC wrap, non-branch, stall.
        drive_br("t3", 1'b1, 16'h000A, 2'b00, 16'h0000, 1'b0, 16'h0040, 1'b1, 1'b0, 16'h000C);
        tick(); idle(); tick(); tick();
        drive_br("t3b", 1'b1, 16'h0100, 2'b11, 16'h0100, 1'b1, 16'h0120, 1'b1, 1'b1, 16'h0120);
        tick(); idle(); tick(); tick();
        drive_br("t3c", 1'b1, 16'hFFFE, 2'b10, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h0000);
        tick(); idle(); tick(); tick();
        drive_br("t3d", 1'b0, 16'h0004, 2'b00, 16'h0000, 1'b1, 16'h0055, 1'b0, 1'b0, 16'h0055);
        tick();
        enable = 1'b0;
        drive_br("t3e", 1'b1, 16'h0004, 2'b00, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040);
        tick(); idle(); enable = 1'b1; tick(); tick();

        // 4: conflicting lookup blocks the update for STARVE_LIM cycles.
        lookup_valid = 1'b1;
        PC_curr      = 16'h0008;
        drive_br("t4", 1'b1, 16'h0008, 2'b01, 16'h0080, 1'b1, 16'h0080, 1'b1, 1'b1, 16'h0080);
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            #2;
            check("t4_blocked_wen", tbl_wen, 0);
            check("t4_blocked_stall", lookup_stall, 0);
`ifdef BP_FWD_EN
            check("t4_fwd_hit", fwd_hit, 1);
            check("t4_fwd_ctr", fwd_counter, 2'b10);
            check("t4_fwd_tgt", fwd_target, 16'h0080);
`endif
            tick();
        end
        #2;
        check("t4_preempt_wen", tbl_wen, 1);
        check("t4_preempt_stall", lookup_stall, 1);
        tick(); #2;
        check("t4_after_wen", tbl_wen, 0);
        check("t4_after_stall", lookup_stall, 0);
`ifdef BP_FWD_EN
        check("t4_fwd_drained", fwd_hit, 0);
`endif
        tick();

        // 4b: a lookup to another index does not block the update.
        PC_curr = 16'h0002;
        drive_br("t4b", 1'b1, 16'h0008, 2'b11, 16'h0080, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0080);
        tick(); idle(); #2;
        check("t4b_wen", tbl_wen, 1);
        check("t4b_stall", lookup_stall, 0);
        tick(); tick();

        // 5: fill, drop while full, accept while full with a pop, drain in order.
        PC_curr = 16'h0008;
        drive_br("t5a", 1'b1, 16'h0008, 2'b01, 16'h0080, 1'b1, 16'h0080, 1'b1, 1'b1, 16'h0080);
        tick();
        drive_br("t5b", 1'b1, 16'h0018, 2'b11, 16'h0000, 1'b0, 16'h0200, 1'b1, 1'b1, 16'h001A);
        tick();
        check("t5_full", upd_full, 1);
        drive_br("t5c", 1'b1, 16'h0028, 2'b00, 16'h0000, 1'b1, 16'h0300, 1'b0, 1'b1, 16'h0300);
        tick(); idle(); #2;
        check("t5_hold_wen", tbl_wen, 0);
        check("t5_hold_full", upd_full, 1);
        tick(); #2;
        check("t5_pop_wen", tbl_wen, 1);
        check("t5_pop_stall", lookup_stall, 1);
        drive_br("t5d", 1'b1, 16'h0038, 2'b10, 16'h0400, 1'b1, 16'h0400, 1'b1, 1'b0, 16'h0400);
        tick(); idle(); lookup_valid = 1'b0; #2;
        check("t5_refill_full", upd_full, 1);
        check("t5_drain1_wen", tbl_wen, 1);
        tick(); #2;
        check("t5_drain2_wen", tbl_wen, 1);
        check("t5_drain2_full", upd_full, 0);
        tick(); #2;
        check("t5_drained_wen", tbl_wen, 0);
        tick();

        // 5b: reset while the FIFO holds entries discards them.
        lookup_valid = 1'b1;
        drive_br("t5e", 1'b1, 16'h0008, 2'b00, 16'h0000, 1'b1, 16'h0500, 1'b1, 1'b1, 16'h0500);
        tick();
        drive_br("t5f", 1'b1, 16'h0008, 2'b01, 16'h0000, 1'b1, 16'h0600, 1'b1, 1'b1, 16'h0600);
        tick(); idle();
        check("t5_prerst_full", upd_full, 1);
        rst = 1'b1;
        #2;
        check("t5_inrst_full", upd_full, 0);
        check("t5_inrst_wen", tbl_wen, 0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        lookup_valid = 1'b0;
        #2;
        check("t5_postrst_wen", tbl_wen, 0);
        check("t5_postrst_full", upd_full, 0);
        tick(); tick(); tick();

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
